// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the control unit (master)
// and the word-wide memory slave (slave).
//   MemReq  : request valid
//   MemWR   : 1 = write, 0 = read, sampled with MemReq
//   Address : byte address
//   DataIn  : write data
//   DataOut : read data, valid while Ready
//   Ready   : one-cycle completion pulse
//   Busy    : request in flight; new requests are ignored while high
//   Error   : with Ready, the completed request was misaligned
interface mem_responder_if;
  logic        MemReq;
  logic        MemWR;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ready;
  logic        Busy;
  logic        Error;

  modport master (
    output MemReq, MemWR, Address, DataIn,
    input  DataOut, Ready, Busy, Error
  );

  modport slave (
    input  MemReq, MemWR, Address, DataIn,
    output DataOut, Ready, Busy, Error
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory slave for the control unit's memory port.
// One request at a time is latched in IDLE, held for LATENCY edges, and completed
// with a one-cycle Ready pulse. The access commits on the edge that enters DONE.
//   Clk   : clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : mem_responder_if slave modport (request in, DataOut/Ready/Busy/Error out)
// All outputs come straight from registers.
module mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic            Clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] LastCount = 4'(LATENCY - 1);

  state_e            state_q;
  logic [3:0]        count_q;
  logic              wr_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       data_q;
  logic [31:0]       data_out_q;
  logic              error_q;

  logic [31:0] mem [1 << ADDR_W];

  logic              accept;
  logic              commit;
  logic              cm_wr;
  logic [ADDR_W+1:0] cm_addr;
  logic [31:0]       cm_data;
  logic              cm_misaligned;
  logic [ADDR_W-1:0] cm_idx;

  // Address bits above the word index alias; they are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.Address[31:ADDR_W+2];

  always_comb begin
    accept = (state_q == StIdle) && bus.MemReq;
    // With LATENCY==1 the accepting edge is also the commit edge, so the access
    // must be taken from the live inputs rather than the (not yet loaded) latches.
    if (LATENCY == 1) begin
      commit = accept;
    end else begin
      commit = (state_q == StWait) && (count_q == LastCount);
    end
    if (state_q == StIdle) begin
      cm_wr   = bus.MemWR;
      cm_addr = bus.Address[ADDR_W+1:0];
      cm_data = bus.DataIn;
    end else begin
      cm_wr   = wr_q;
      cm_addr = addr_q;
      cm_data = data_q;
    end
    cm_misaligned = (cm_addr[1:0] != 2'b00);
    cm_idx        = cm_addr[ADDR_W+1:2];
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      data_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.MemReq) begin
            wr_q   <= bus.MemWR;
            addr_q <= bus.Address[ADDR_W+1:0];
            data_q <= bus.DataIn;
            if (LATENCY == 1) begin
              state_q <= StDone;
            end else begin
              state_q <= StWait;
              count_q <= 4'd1;
            end
          end
        end
        StWait: begin
          count_q <= count_q + 4'd1;
          if (count_q == LastCount) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          error_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      if (commit) begin
        error_q <= cm_misaligned;
        if (!cm_wr && !cm_misaligned) begin
          data_out_q <= mem[cm_idx];
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (!reset && commit && cm_wr && !cm_misaligned) begin
      mem[cm_idx] <= cm_data;
    end
  end

  assign bus.Busy    = (state_q != StIdle);
  assign bus.Ready   = (state_q == StDone);
  assign bus.Error   = error_q;
  assign bus.DataOut = data_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder with a
// word-array reference model of the memory and the last-read data register.
module tb_mem_responder;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LATENCY = 2;

  logic Clk   = 1'b0;
  logic reset = 1'b1;

  mem_responder_if bus();

  mem_responder #(
    .ADDR_W (ADDR_W),
    .LATENCY(LATENCY)
  ) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model
  logic [31:0] ref_mem   [1 << ADDR_W];
  bit          ref_known [1 << ADDR_W];
  logic [31:0] exp_dout;
  bit          dout_known;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Applies one completed access to the model; returns the expected Error.
  function automatic bit model_commit(input bit wr, input logic [31:0] addr,
                                      input logic [31:0] data);
    int idx;
    idx = int'(addr[ADDR_W+1:2]);
    if (addr[1:0] != 2'b00) return 1'b1;
    if (wr) begin
      ref_mem[idx]   = data;
      ref_known[idx] = 1'b1;
    end else begin
      exp_dout   = ref_mem[idx];
      dout_known = ref_known[idx];
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    exp_dout   = 32'h0;
    dout_known = 1'b1;
  endfunction

  // Issue one request from IDLE and check latency, Error and DataOut.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input string name);
    int cnt;
    bit exp_err;
    bus.MemReq  = 1'b1;
    bus.MemWR   = wr;
    bus.Address = addr;
    bus.DataIn  = data;
    step();
    // Scramble inputs while busy; they must not affect the in-flight access.
    bus.MemReq  = 1'b0;
    bus.MemWR   = ~wr;
    bus.Address = $urandom;
    bus.DataIn  = $urandom;
    cnt = 1;
    while (bus.Ready !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    exp_err = model_commit(wr, addr, data);
    vectors++;
    if (cnt != LATENCY) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, cnt, LATENCY);
    end
    vectors++;
    if (bus.Error !== exp_err) begin
      errors++;
      $display("FAIL %s error: got %b expected %b", name, bus.Error, exp_err);
    end
    if (dout_known) begin
      vectors++;
      if (bus.DataOut !== exp_dout) begin
        errors++;
        $display("FAIL %s dataout: got %h expected %h", name, bus.DataOut, exp_dout);
      end
    end
    step();
    vectors++;
    if (bus.Ready !== 1'b0 || bus.Busy !== 1'b0 || bus.Error !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after done: got ready=%b busy=%b error=%b expected 0 0 0",
               name, bus.Ready, bus.Busy, bus.Error);
    end
  endtask

  task automatic test_reset();
    // Reset together with a live request: reset must win.
    reset      = 1'b1;
    bus.MemReq = 1'b1;
    bus.MemWR  = 1'b1;
    bus.Address = 32'h0;
    bus.DataIn  = 32'h0;
    step();
    step();
    model_reset();
    vectors++;
    if ({bus.Busy, bus.Ready, bus.Error} !== 3'b000 || bus.DataOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ready=%b error=%b dout=%h expected 0 0 0 0",
               bus.Busy, bus.Ready, bus.Error, bus.DataOut);
    end
    reset      = 1'b0;
    bus.MemReq = 1'b0;
    step();
    vectors++;
    if (bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b expected 0", bus.Busy);
    end
  endtask

  task automatic test_directed();
    bit e;
    // Cycle-exact write of 0xDEADBEEF to 0x10.
    bus.MemReq  = 1'b1;
    bus.MemWR   = 1'b1;
    bus.Address = 32'h10;
    bus.DataIn  = 32'hDEADBEEF;
    step();
    bus.MemReq = 1'b0;
    vectors++;
    if (bus.Busy !== 1'b1 || bus.Ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_cycle1: got busy=%b ready=%b expected 1 0", bus.Busy, bus.Ready);
    end
    step();
    vectors++;
    if (bus.Busy !== 1'b1 || bus.Ready !== 1'b1 || bus.Error !== 1'b0) begin
      errors++;
      $display("FAIL wr_cycle2: got busy=%b ready=%b error=%b expected 1 1 0",
               bus.Busy, bus.Ready, bus.Error);
    end
    step();
    vectors++;
    if (bus.Busy !== 1'b0 || bus.Ready !== 1'b0) begin
      errors++;
      $display("FAIL wr_cycle3: got busy=%b ready=%b expected 0 0", bus.Busy, bus.Ready);
    end
    e = model_commit(1'b1, 32'h10, 32'hDEADBEEF);

    do_req(1'b0, 32'h10, 32'h0, "read_0x10");
    do_req(1'b1, 32'h13, 32'h12345678, "misaligned_wr");
    do_req(1'b0, 32'h10, 32'h0, "read_after_misaligned");
    do_req(1'b0, 32'h410, 32'h0, "alias_read");
    do_req(1'b0, 32'h11, 32'h0, "misaligned_rd");
  endtask

  task automatic test_reset_mid();
    do_req(1'b1, 32'h20, 32'h11112222, "prior_wr_0x20");
    // Abort in WAIT: write must not land.
    bus.MemReq  = 1'b1;
    bus.MemWR   = 1'b1;
    bus.Address = 32'h20;
    bus.DataIn  = 32'hCAFEF00D;
    step();
    bus.MemReq = 1'b0;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    vectors++;
    if ({bus.Busy, bus.Ready, bus.Error} !== 3'b000 || bus.DataOut !== 32'h0) begin
      errors++;
      $display("FAIL abort_wait_outputs: got busy=%b ready=%b error=%b dout=%h expected 0",
               bus.Busy, bus.Ready, bus.Error, bus.DataOut);
    end
    step();
    vectors++;
    if (bus.Ready !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait_no_ready: got ready=%b busy=%b expected 0 0",
               bus.Ready, bus.Busy);
    end
    do_req(1'b0, 32'h20, 32'h0, "read_after_abort");

    // Reset in DONE: the write has already committed.
    bus.MemReq  = 1'b1;
    bus.MemWR   = 1'b1;
    bus.Address = 32'h24;
    bus.DataIn  = 32'hA5A55A5A;
    step();
    bus.MemReq = 1'b0;
    step();
    vectors++;
    if (bus.Ready !== 1'b1) begin
      errors++;
      $display("FAIL done_before_reset: got ready=%b expected 1", bus.Ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(model_commit(1'b1, 32'h24, 32'hA5A55A5A));
    model_reset();
    vectors++;
    if (bus.Ready !== 1'b0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: got ready=%b busy=%b expected 0 0", bus.Ready, bus.Busy);
    end
    do_req(1'b0, 32'h24, 32'h0, "read_after_done_reset");
  endtask

  task automatic test_back_to_back();
    bit          p_wr;
    logic [31:0] p_addr;
    logic [31:0] p_data;
    bit          exp_err;
    for (int w = 0; w < 8; w++) begin
      do_req(1'b1, 32'h40 + 32'(w * 4), $urandom, "b2b_prefill");
    end
    p_wr = 1'b0;
    p_addr = 32'h0;
    p_data = 32'h0;
    for (int k = 0; k < 30; k++) begin
      bus.MemReq  = 1'b1;
      bus.MemWR   = $urandom_range(0, 1) == 1;
      bus.Address = ($urandom & 32'hFFFF_FC00) | (32'h40 + 32'($urandom_range(0, 7) * 4));
      if ($urandom_range(0, 5) == 0) bus.Address[1:0] = 2'($urandom_range(1, 3));
      bus.DataIn = $urandom;
      if (k % 3 == 0) begin
        p_wr   = bus.MemWR;
        p_addr = bus.Address;
        p_data = bus.DataIn;
      end
      step();
      vectors++;
      if (bus.Ready !== (k % 3 == 1) || bus.Busy !== (k % 3 != 2)) begin
        errors++;
        $display("FAIL b2b_timing k=%0d: got ready=%b busy=%b expected %b %b", k,
                 bus.Ready, bus.Busy, (k % 3 == 1), (k % 3 != 2));
      end
      if (k % 3 == 1) begin
        exp_err = model_commit(p_wr, p_addr, p_data);
        vectors++;
        if (bus.Error !== exp_err || (dout_known && bus.DataOut !== exp_dout)) begin
          errors++;
          $display("FAIL b2b_result k=%0d: got err=%b dout=%h expected err=%b dout=%h", k,
                   bus.Error, bus.DataOut, exp_err, exp_dout);
        end
      end
    end
    bus.MemReq = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [31:0] a;
    bit          wr;
    for (int n = 0; n < 40; n++) begin
      wr = $urandom_range(0, 1) == 1;
      a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_req(wr, a, $urandom, "random");
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
  endtask

  initial begin
    bus.MemReq  = 1'b0;
    bus.MemWR   = 1'b0;
    bus.Address = 32'h0;
    bus.DataIn  = 32'h0;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_known[i] = 1'b0;
    model_reset();
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
